// File: rtl/mips_defs.sv
// Shared definitions for the MIPS pipeline control blocks: MDU opcodes,
// operand-usage encodings, MDU latency defaults and hazard helpers.
package mips_defs;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    localparam logic [1:0] TUSE_NONE       = 2'd3;
    localparam int         MULT_CYCLES_DEF = 5;
    localparam int         DIV_CYCLES_DEF  = 10;
    localparam logic [4:0] REG_ZERO        = 5'd0;

    function automatic logic is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // A producer blocks a consumer when its result arrives later than the consumer needs it.
    function automatic logic reg_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                        input logic [4:0] dst, input logic [1:0] tnew);
        return (src != REG_ZERO) && (src == dst) && (tnew > tuse);
    endfunction

endpackage

// File: rtl/md_sequencer.sv
// Multiply/divide occupancy tracker: counts the MDU latency after a start
// strobe and pulses md_done in the cycle HI/LO become valid.
module md_sequencer
    import mips_defs::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       md_start,
    input  logic [1:0] md_op,
    output logic       md_busy,
    output logic       md_done
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             md_done_q, md_done_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        md_done_d = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (md_start) begin
                    cnt_d   = is_div(md_op_e'(md_op)) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    state_d = MD_RUN;
                end
            end
            MD_RUN: begin
                // A start strobe here is ignored: the issuing instruction is held in D.
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d   = MD_IDLE;
                    md_done_d = 1'b1;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            md_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            md_done_q <= md_done_d;
        end
    end

    assign md_busy = md_start | (state_q == MD_RUN);
    assign md_done = md_done_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: holds the D-stage instruction on Tuse/Tnew
// data hazards or while the MDU is busy, and inserts bubbles into D/E.
module hazard_stall_ctrl
    import mips_defs::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_tuse_rs,
    input  logic [1:0] D_tuse_rt,
    input  logic [4:0] E_dst,
    input  logic [4:0] M_dst,
    input  logic [1:0] E_tnew,
    input  logic [1:0] M_tnew,
    input  logic       D_is_md,
    input  logic       E_md_start,
    input  logic [1:0] E_md_op,
    output logic       F_en,
    output logic       D_en,
    output logic       E_clr,
    output logic       stall,
    output logic       md_busy,
    output logic       md_done
);

    logic stall_rs, stall_rt, stall_md;

    md_sequencer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_sequencer (
        .clk      (clk),
        .reset    (reset),
        .md_start (E_md_start),
        .md_op    (E_md_op),
        .md_busy  (md_busy),
        .md_done  (md_done)
    );

    // E and M are checked independently; a match in either stage is enough to hold D.
    assign stall_rs = reg_hazard(D_rs, D_tuse_rs, E_dst, E_tnew) |
                      reg_hazard(D_rs, D_tuse_rs, M_dst, M_tnew);
    assign stall_rt = reg_hazard(D_rt, D_tuse_rt, E_dst, E_tnew) |
                      reg_hazard(D_rt, D_tuse_rt, M_dst, M_tnew);
    assign stall_md = D_is_md & md_busy;

    assign stall = stall_rs | stall_rt | stall_md;
    assign F_en  = ~stall;
    assign D_en  = ~stall;
    assign E_clr = stall;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus
// randomized traffic compared against a cycle-numbered reference model.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs, D_rt, E_dst, M_dst;
    logic [1:0] D_tuse_rs, D_tuse_rt, E_tnew, M_tnew, E_md_op;
    logic       D_is_md, E_md_start;
    logic       F_en, D_en, E_clr, stall, md_busy, md_done;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: absolute cycle numbers of the last RUN cycle and the done cycle.
    int cyc      = 0;
    int run_end  = -1;
    int done_at  = -1;

    hazard_stall_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .D_rs       (D_rs),
        .D_rt       (D_rt),
        .D_tuse_rs  (D_tuse_rs),
        .D_tuse_rt  (D_tuse_rt),
        .E_dst      (E_dst),
        .M_dst      (M_dst),
        .E_tnew     (E_tnew),
        .M_tnew     (M_tnew),
        .D_is_md    (D_is_md),
        .E_md_start (E_md_start),
        .E_md_op    (E_md_op),
        .F_en       (F_en),
        .D_en       (D_en),
        .E_clr      (E_clr),
        .stall      (stall),
        .md_busy    (md_busy),
        .md_done    (md_done)
    );

    always #5 clk = ~clk;

    function automatic bit ref_data_stall();
        int src [2];
        int tuse[2];
        int dst [2];
        int tnew[2];
        src[0] = D_rs;  tuse[0] = D_tuse_rs;
        src[1] = D_rt;  tuse[1] = D_tuse_rt;
        dst[0] = E_dst; tnew[0] = E_tnew;
        dst[1] = M_dst; tnew[1] = M_tnew;
        for (int s = 0; s < 2; s++) begin
            if (src[s] == 0) continue;
            for (int p = 0; p < 2; p++)
                if (dst[p] == src[s] && tnew[p] > tuse[s]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit ref_busy();
        return E_md_start || (cyc <= run_end);
    endfunction

    function automatic bit ref_done();
        return cyc == done_at;
    endfunction

    function automatic bit ref_stall();
        return ref_data_stall() || (D_is_md && ref_busy());
    endfunction

    task automatic idle_inputs();
        D_rs = 0; D_rt = 0; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3;
        E_dst = 0; M_dst = 0; E_tnew = 0; M_tnew = 0;
        D_is_md = 0; E_md_start = 0; E_md_op = 0;
    endtask

    // Advance one clock; update the model with the inputs of the cycle just ending.
    task automatic tick();
        @(posedge clk);
        if (!reset && E_md_start && cyc > run_end) begin
            run_end = cyc + (E_md_op[1] ? 10 : 5);
            done_at = run_end + 1;
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        #12;
        n_checks++;
        if ({F_en, D_en, E_clr, stall} !== 4'b1100) $display("FAIL reset_enables got=%b want=1100", {F_en, D_en, E_clr, stall});
        else n_pass++;
        n_checks++;
        if ({md_busy, md_done} !== 2'b00) $display("FAIL reset_mdu got=%b want=00", {md_busy, md_done});
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        run_end = -1; done_at = -1;
        tick();
        n_checks++;
        if (md_done !== 1'b0 || md_busy !== 1'b0) $display("FAIL post_reset_idle busy=%b done=%b want 0/0", md_busy, md_done);
        else n_pass++;
    endtask

    task automatic test_raw_hazard();
        idle_inputs();
        E_dst = 5'd1; E_tnew = 2'd2; D_rs = 5'd1; D_tuse_rs = 2'd1;
        #2;
        n_checks++;
        if ({stall, E_clr, F_en, D_en} !== 4'b1100) $display("FAIL load_use_E got=%b want=1100", {stall, E_clr, F_en, D_en});
        else n_pass++;
        tick();
        E_dst = 0; E_tnew = 0; M_dst = 5'd1; M_tnew = 2'd1;
        #2;
        n_checks++;
        if (stall !== 1'b0 || F_en !== 1'b1) $display("FAIL load_use_M stall=%b F_en=%b want 0/1", stall, F_en);
        else n_pass++;
        tick();
        idle_inputs();
        D_rt = 5'd3; D_tuse_rt = 2'd0; M_dst = 5'd3; M_tnew = 2'd1;
        #2;
        n_checks++;
        if (stall !== 1'b1) $display("FAIL rt_from_M got=%b want=1", stall);
        else n_pass++;
        tick();
        idle_inputs();
        D_rs = 5'd7; D_tuse_rs = 2'd1; E_dst = 5'd7; E_tnew = 2'd0; M_dst = 5'd7; M_tnew = 2'd2;
        #2;
        n_checks++;
        if (stall !== 1'b1) $display("FAIL both_match_M_late got=%b want=1", stall);
        else n_pass++;
        D_tuse_rs = 2'd3; M_tnew = 2'd2; E_tnew = 2'd2;
        #1;
        n_checks++;
        if (stall !== 1'b0) $display("FAIL tuse_none got=%b want=0", stall);
        else n_pass++;
        tick();
    endtask

    task automatic test_reg_zero();
        idle_inputs();
        E_dst = 0; E_tnew = 2'd2; D_rs = 0; D_tuse_rs = 2'd0;
        M_dst = 0; M_tnew = 2'd3; D_rt = 0; D_tuse_rt = 2'd0;
        #2;
        n_checks++;
        if (stall !== 1'b0 || E_clr !== 1'b0) $display("FAIL reg_zero stall=%b E_clr=%b want 0/0", stall, E_clr);
        else n_pass++;
        tick();
    endtask

    task automatic run_md(input logic [1:0] op, input int n, input bit hold_md, input int restart_k);
        idle_inputs();
        D_is_md = hold_md;
        E_md_start = 1'b1; E_md_op = op;
        for (int k = 0; k <= n + 2; k++) begin
            if (k == restart_k) begin E_md_start = 1'b1; E_md_op = 2'b10; end
            #2;
            n_checks++;
            if (md_busy !== (k <= n)) $display("FAIL md_busy op=%0d k=%0d got=%b want=%b", op, k, md_busy, (k <= n));
            else n_pass++;
            n_checks++;
            if (md_done !== (k == n + 1)) $display("FAIL md_done op=%0d k=%0d got=%b want=%b", op, k, md_done, (k == n + 1));
            else n_pass++;
            n_checks++;
            if (stall !== (hold_md && k <= n)) $display("FAIL md_stall op=%0d k=%0d got=%b want=%b", op, k, stall, (hold_md && k <= n));
            else n_pass++;
            tick();
            E_md_start = 1'b0;
        end
    endtask

    task automatic test_mult();
        run_md(2'b00, 5, 1'b1, -1);
    endtask

    task automatic test_div();
        run_md(2'b10, 10, 1'b0, -1);
    endtask

    task automatic test_restart_ignored();
        run_md(2'b01, 5, 1'b1, 2);
    endtask

    task automatic test_reset_abort();
        idle_inputs();
        E_md_start = 1'b1; E_md_op = 2'b11;
        tick();
        E_md_start = 1'b0;
        tick(); tick();
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (md_busy !== 1'b0 || md_done !== 1'b0) $display("FAIL abort_now busy=%b done=%b want 0/0", md_busy, md_done);
        else n_pass++;
        run_end = -1; done_at = -1;
        #1 reset = 1'b0;
        for (int k = 4; k <= 13; k++) begin
            tick();
            #2;
            n_checks++;
            if (md_done !== 1'b0 || md_busy !== 1'b0) $display("FAIL abort_quiet k=%0d busy=%b done=%b want 0/0", k, md_busy, md_done);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        D_is_md = 1'b1;
        E_md_start = 1'b1; E_md_op = 2'b00;
        for (int k = 0; k <= 13; k++) begin
            if (k == 6) E_md_start = 1'b1;
            #2;
            n_checks++;
            if (md_done !== (k == 6 || k == 12)) $display("FAIL b2b_done k=%0d got=%b want=%b", k, md_done, (k == 6 || k == 12));
            else n_pass++;
            n_checks++;
            if (md_busy !== (k <= 11)) $display("FAIL b2b_busy k=%0d got=%b want=%b", k, md_busy, (k <= 11));
            else n_pass++;
            tick();
            E_md_start = 1'b0;
        end
    endtask

    task automatic test_random();
        bit exp_stall;
        for (int i = 0; i < 400; i++) begin
            D_rs = 5'($urandom_range(0, 3));   D_rt = 5'($urandom_range(0, 3));
            E_dst = 5'($urandom_range(0, 3));  M_dst = 5'($urandom_range(0, 3));
            D_tuse_rs = 2'($urandom); D_tuse_rt = 2'($urandom);
            E_tnew = 2'($urandom);    M_tnew = 2'($urandom);
            D_is_md = 1'($urandom);
            E_md_start = ($urandom_range(0, 7) == 0);
            E_md_op = 2'($urandom);
            #2;
            exp_stall = ref_stall();
            n_checks++;
            if ({stall, E_clr, F_en, D_en} !== {exp_stall, exp_stall, !exp_stall, !exp_stall})
                $display("FAIL rnd_stall i=%0d got=%b want=%b", i, {stall, E_clr, F_en, D_en},
                         {exp_stall, exp_stall, !exp_stall, !exp_stall});
            else n_pass++;
            n_checks++;
            if ({md_busy, md_done} !== {ref_busy(), ref_done()})
                $display("FAIL rnd_mdu i=%0d got=%b want=%b", i, {md_busy, md_done}, {ref_busy(), ref_done()});
            else n_pass++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_raw_hazard();
        test_reg_zero();
        test_mult();
        test_div();
        test_reset_abort();
        test_restart_ignored();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
